// File: rtl/bumper_pkg.sv
// Shared types and constants for the bumper maneuver controller.
// The state enum, per-state motor pin encodings and default cycle counts live here.
package bumper_pkg;

   localparam int unsigned DEF_DEBOUNCE_CYCLES = 16;
   localparam int unsigned DEF_BACK_CYCLES     = 1000;
   localparam int unsigned DEF_TURN_CYCLES     = 500;
   localparam int unsigned DEF_CNT_W           = 16;
   localparam int unsigned STATE_W             = 3;
   localparam int unsigned RETRY_W             = 2;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE   = 3'd0,
      ST_FWD    = 3'd1,
      ST_BACK   = 3'd2,
      ST_TURN_L = 3'd3,
      ST_TURN_R = 3'd4,
      ST_HALT   = 3'd5
   } state_e;

   // Enables are active-low; dir=1 means forward.
   typedef struct packed {
      logic len;
      logic ldir;
      logic ren;
      logic rdir;
   } motor_t;

   localparam motor_t MOT_STOP   = '{len: 1'b1, ldir: 1'b0, ren: 1'b1, rdir: 1'b0};
   localparam motor_t MOT_FWD    = '{len: 1'b0, ldir: 1'b1, ren: 1'b0, rdir: 1'b1};
   localparam motor_t MOT_BACK   = '{len: 1'b0, ldir: 1'b0, ren: 1'b0, rdir: 1'b0};
   localparam motor_t MOT_TURN_L = '{len: 1'b1, ldir: 1'b0, ren: 1'b0, rdir: 1'b1};
   localparam motor_t MOT_TURN_R = '{len: 1'b0, ldir: 1'b1, ren: 1'b1, rdir: 1'b0};

   function automatic motor_t motor_decode(input state_e s);
      motor_t m;
      case (s)
         ST_FWD:    m = MOT_FWD;
         ST_BACK:   m = MOT_BACK;
         ST_TURN_L: m = MOT_TURN_L;
         ST_TURN_R: m = MOT_TURN_R;
         default:   m = MOT_STOP;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/bump_debounce.sv
// Bumper input conditioning: 2-flop synchronizer then a saturating press counter.
// level_o rises after DEBOUNCE_CYCLES pressed samples and drops on the first released one.
module bump_debounce
   import bumper_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int unsigned CNT_W           = DEF_CNT_W
) (
   input  logic clk,
   input  logic reset,
   input  logic bumper_n_i,
   output logic level_o
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

   logic [1:0]       sync_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             level_q;

   always_comb begin
      cnt_d = cnt_q;
      if (sync_q[1]) begin
         cnt_d = '0;
      end else if (cnt_q != CNT_MAX) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_q  <= 2'b11;
         cnt_q   <= '0;
         level_q <= 1'b0;
      end else begin
         sync_q  <= {sync_q[0], bumper_n_i};
         cnt_q   <= cnt_d;
         level_q <= (cnt_d == CNT_MAX);
      end
   end

   assign level_o = level_q;

endmodule

// File: rtl/bump_maneuver_ctrl.sv
// Bumper robot maneuver sequencer: FWD, then BACK / pivot phases on a debounced bump.
// Define BUMPCTRL_RETRY_EN to re-back while the bumper stays pressed, halting after three retries.
module bump_maneuver_ctrl
   import bumper_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int unsigned BACK_CYCLES     = DEF_BACK_CYCLES,
   parameter int unsigned TURN_CYCLES     = DEF_TURN_CYCLES,
   parameter int unsigned CNT_W           = DEF_CNT_W
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               run,
   input  logic               l_bumper,
   input  logic               r_bumper,
   output logic               len,
   output logic               ldir,
   output logic               ren,
   output logic               rdir,
   output logic               busy,
   output logic [STATE_W-1:0] state
);

   localparam logic [CNT_W-1:0] BACK_LD  = CNT_W'(BACK_CYCLES);
   localparam logic [CNT_W-1:0] TURN_LD  = CNT_W'(TURN_CYCLES);
   localparam logic [CNT_W-1:0] TURN2_LD = CNT_W'(2 * TURN_CYCLES);
   localparam logic [CNT_W-1:0] PHASE_LAST = CNT_W'(1);

   logic l_lvl, r_lvl;
   logic l_prev_q, r_prev_q;
   logic l_rise, r_rise;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] phase_q, phase_d;
   logic             turn_l_q, turn_l_d;  // pivot left (right side was hit)
   logic             dbl_q, dbl_d;        // both sides hit together: double-length pivot
   motor_t           mot;

   bump_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_deb_l (
      .clk        (clk),
      .reset      (reset),
      .bumper_n_i (l_bumper),
      .level_o    (l_lvl)
   );

   bump_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_deb_r (
      .clk        (clk),
      .reset      (reset),
      .bumper_n_i (r_bumper),
      .level_o    (r_lvl)
   );

   assign l_rise = l_lvl & ~l_prev_q;
   assign r_rise = r_lvl & ~r_prev_q;

`ifdef BUMPCTRL_RETRY_EN
   logic [RETRY_W-1:0] retry_q, retry_d;
   logic               side_pressed;

   assign side_pressed = dbl_q    ? (l_lvl | r_lvl) :
                         turn_l_q ? r_lvl : l_lvl;
`endif

   // Next-state and phase counter
   always_comb begin
      state_d  = state_q;
      phase_d  = phase_q;
      turn_l_d = turn_l_q;
      dbl_d    = dbl_q;
`ifdef BUMPCTRL_RETRY_EN
      retry_d  = retry_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (run) begin
               state_d = ST_FWD;
`ifdef BUMPCTRL_RETRY_EN
               retry_d = '0;
`endif
            end
         end
         ST_FWD: begin
            if (!run) begin
               state_d = ST_IDLE;
            end else if (l_rise || r_rise) begin
               state_d  = ST_BACK;
               phase_d  = BACK_LD;
               turn_l_d = r_rise & ~l_rise;
               dbl_d    = l_rise & r_rise;
            end
         end
         ST_BACK: begin
            if (phase_q == PHASE_LAST) begin
               state_d = turn_l_q ? ST_TURN_L : ST_TURN_R;
               phase_d = dbl_q ? TURN2_LD : TURN_LD;
            end else begin
               phase_d = phase_q - CNT_W'(1);
            end
         end
         ST_TURN_L, ST_TURN_R: begin
            if (phase_q == PHASE_LAST) begin
               phase_d = '0;
`ifdef BUMPCTRL_RETRY_EN
               if (side_pressed) begin
                  if (retry_q == RETRY_W'(2)) begin
                     state_d = ST_HALT;
                  end else begin
                     state_d = ST_BACK;
                     phase_d = BACK_LD;
                     retry_d = retry_q + RETRY_W'(1);
                  end
               end else if (run) begin
                  state_d = ST_FWD;
                  retry_d = '0;
               end else begin
                  state_d = ST_IDLE;
               end
`else
               state_d = run ? ST_FWD : ST_IDLE;
`endif
            end else begin
               phase_d = phase_q - CNT_W'(1);
            end
         end
         ST_HALT: state_d = ST_HALT;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= ST_IDLE;
         phase_q  <= '0;
         turn_l_q <= 1'b0;
         dbl_q    <= 1'b0;
         l_prev_q <= 1'b0;
         r_prev_q <= 1'b0;
`ifdef BUMPCTRL_RETRY_EN
         retry_q  <= '0;
`endif
      end else begin
         state_q  <= state_d;
         phase_q  <= phase_d;
         turn_l_q <= turn_l_d;
         dbl_q    <= dbl_d;
         l_prev_q <= l_lvl;
         r_prev_q <= r_lvl;
`ifdef BUMPCTRL_RETRY_EN
         retry_q  <= retry_d;
`endif
      end
   end

   // Moore outputs decoded straight from the state register
   assign mot   = motor_decode(state_q);
   assign len   = mot.len;
   assign ldir  = mot.ldir;
   assign ren   = mot.ren;
   assign rdir  = mot.rdir;
   assign busy  = (state_q == ST_BACK) || (state_q == ST_TURN_L) || (state_q == ST_TURN_R);
   assign state = state_q;

endmodule

// File: tb/tb_bump_maneuver_ctrl.sv
// Directed bench for bump_maneuver_ctrl with short debounce/back/turn counts.
// The permanent-press scenario follows BUMPCTRL_RETRY_EN as the design does.
module tb_bump_maneuver_ctrl;

   localparam int unsigned DEB = 4;
   localparam int unsigned BK  = 8;
   localparam int unsigned TN  = 6;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       run = 1'b0;
   logic       l_bumper = 1'b1;
   logic       r_bumper = 1'b1;
   logic       len, ldir, ren, rdir, busy;
   logic [2:0] state;

   int n_tests = 0;
   int n_fail  = 0;

   bump_maneuver_ctrl #(
      .DEBOUNCE_CYCLES (DEB),
      .BACK_CYCLES     (BK),
      .TURN_CYCLES     (TN),
      .CNT_W           (16)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .run      (run),
      .l_bumper (l_bumper),
      .r_bumper (r_bumper),
      .len      (len),
      .ldir     (ldir),
      .ren      (ren),
      .rdir     (rdir),
      .busy     (busy),
      .state    (state)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // {len, ldir, ren, rdir, busy} expected for each state code
   function automatic logic [4:0] outs_of(input logic [2:0] s);
      case (s)
         3'd1:    return 5'b01010;
         3'd2:    return 5'b00001;
         3'd3:    return 5'b10011;
         3'd4:    return 5'b01101;
         default: return 5'b10100;
      endcase
   endfunction

   task automatic check_cycle(input string tag, input int i, input logic [2:0] exp_st);
      check_eq($sformatf("%s_state[%0d]", tag, i), 32'(state), 32'(exp_st));
      check_eq($sformatf("%s_outs[%0d]", tag, i), 32'({len, ldir, ren, rdir, busy}), 32'(outs_of(exp_st)));
   endtask

   // Cycle i after the press edge: FWD until 6, BACK 7..14, pivot for turn_len, then FWD
   function automatic logic [2:0] maneuver_state(input int i, input int turn_len, input logic [2:0] turn_st);
      if (i < 7)             return 3'd1;
      if (i < 15)            return 3'd2;
      if (i < 15 + turn_len) return turn_st;
      return 3'd1;
   endfunction

   // Permanent left press with retry: three 14-cycle BACK/TURN_R rounds, then HALT at 49
   function automatic logic [2:0] retry_state(input int i);
      int j;
      if (i < 7) return 3'd1;
      j = i - 7;
      if (j < 42) return ((j % 14) < 8) ? 3'd2 : 3'd4;
      return 3'd5;
   endfunction

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) tick();
      check_cycle("reset", 0, 3'd0);

      reset = 1'b1;
      tick();
      check_cycle("idle_norun", 0, 3'd0);

      run = 1'b1;
      tick();
      check_cycle("run_fwd", 0, 3'd1);

      // Left bump held 10 cycles -> BACK then TURN_R
      l_bumper = 1'b0;
      for (int i = 1; i <= 21; i++) begin
         tick();
         if (i == 10) l_bumper = 1'b1;
         check_cycle("left", i, maneuver_state(i, TN, 3'd4));
      end
      repeat (5) tick();

      // Both bumpers together -> double-length TURN_R
      l_bumper = 1'b0;
      r_bumper = 1'b0;
      for (int i = 1; i <= 27; i++) begin
         tick();
         if (i == 10) begin
            l_bumper = 1'b1;
            r_bumper = 1'b1;
         end
         check_cycle("both", i, maneuver_state(i, 2 * TN, 3'd4));
      end
      repeat (5) tick();

      // Short right glitch is filtered
      r_bumper = 1'b0;
      for (int i = 1; i <= 14; i++) begin
         tick();
         if (i == 3) r_bumper = 1'b1;
         check_cycle("glitch", i, 3'd1);
      end

      // Right bump -> TURN_L; a left bump landing during TURN_L is dropped
      r_bumper = 1'b0;
      for (int i = 1; i <= 25; i++) begin
         tick();
         if (i == 10) r_bumper = 1'b1;
         if (i == 11) l_bumper = 1'b0;
         if (i == 19) l_bumper = 1'b1;
         check_cycle("right", i, maneuver_state(i, TN, 3'd3));
      end
      repeat (5) tick();

      // Asynchronous reset in the middle of BACK
      l_bumper = 1'b0;
      repeat (9) tick();
      check_eq("pre_reset_state", 32'(state), 32'd2);
      reset = 1'b0;
      #1;
      check_cycle("async_reset", 0, 3'd0);
      l_bumper = 1'b1;
      repeat (2) tick();
      reset = 1'b1;
      tick();
      check_cycle("post_reset_fwd", 0, 3'd1);
      repeat (3) tick();

      // Left bumper held permanently
      l_bumper = 1'b0;
`ifdef BUMPCTRL_RETRY_EN
      for (int i = 1; i <= 60; i++) begin
         tick();
         check_cycle("hold_retry", i, retry_state(i));
      end
`else
      for (int i = 1; i <= 40; i++) begin
         tick();
         check_cycle("hold_noretry", i, maneuver_state(i, TN, 3'd4));
      end
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/bump_maneuver_ctrl.md
# bump_maneuver_ctrl

Timed maneuver sequencer for the bumper robot's two drive motors. It debounces the left and right bumper switches and runs a fixed sequence on each hit: drive forward, back up for a programmed time, pivot away from the obstacle for a programmed time, then resume forward. It replaces free-running, clock-divided state stepping with cycle-counted maneuver phases. It drives the motor enable/direction pins directly.

## Interface
- DEBOUNCE_CYCLES, 16: consecutive pressed samples required to accept a bump.
- BACK_CYCLES, 1000: clock cycles spent in reverse per maneuver.
- TURN_CYCLES, 500: clock cycles spent pivoting per single-side maneuver.
- CNT_W, 16: width of the phase and debounce counters; all cycle parameters must be < 2^CNT_W and ≥ 1.

- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- run  input  1  1 = drive enabled; 0 = motors stopped once the current maneuver ends.
- l_bumper  input  1  left bumper, active-low (0 = pressed), asynchronous.
- r_bumper  input  1  right bumper, active-low, asynchronous.
- len  output  1  left motor enable, active-low.
- ldir  output  1  left direction, 1 = forward.
- ren  output  1  right motor enable, active-low.
- rdir  output  1  right direction, 1 = forward.
- busy  output  1  1 while in BACK or TURN_*.
- state  output  3  current state code.

## Operation
- Each bumper passes through a 2-flop synchronizer, then a debouncer. The debounced level asserts after DEBOUNCE_CYCLES consecutive pressed samples and deasserts on the first released sample. The FSM acts on the rising edge of the debounced level.
- States and codes: IDLE=0, FWD=1, BACK=2, TURN_L=3, TURN_R=4, HALT=5. Codes 6 and 7 are illegal and go to IDLE.
- Motor outputs per state, as (len, ldir, ren, rdir):
  - IDLE (1,0,1,0)
  - FWD (0,1,0,1)
  - BACK (0,0,0,0)
  - TURN_L: left stopped, right forward (1,0,0,1)
  - TURN_R: left forward, right stopped (0,1,1,0)
  - HALT (1,0,1,0)
- IDLE → FWD when run=1.
- FWD → IDLE when run=0.
- FWD → BACK on a bump edge. The side is latched at that point: left only → turn right; right only → turn left; both edges in the same cycle → turn right for 2×TURN_CYCLES.
- BACK → TURN_x after BACK_CYCLES cycles.
- TURN_x → FWD after its cycle count if run=1, otherwise → IDLE.
- Bump edges during BACK or TURN_x are ignored (not queued).
- run=0 during a maneuver does not abort it.
- The phase counter loads on state entry and counts down. The transition fires in the cycle the counter reads 1, so each phase lasts exactly its parameter in cycles.
- HALT is reachable only with the macro enabled (see Configuration).

## Timing
- Moore outputs, decoded from the state register. Outputs are glitch-free but combinational from the register.
- Reset values:
  - state=IDLE
  - len=1, ldir=0, ren=1, rdir=0, busy=0
  - counters 0; synchronizers in the released state (1); retry counter 0.
- Reset mid-maneuver forces IDLE immediately and asynchronously. The latched side is discarded.
- Bump latency: a pressed edge at the pin reaches BACK at 2 (sync) + DEBOUNCE_CYCLES + 1 cycles.
- Release latency: 3 cycles.
- run latency: 1 cycle from IDLE/FWD.

## Configuration
- BUMPCTRL_RETRY_EN defined:
  - At TURN_x expiry, if the debounced bumper on the latched side is still pressed, re-enter BACK instead of FWD.
  - A 2-bit retry counter increments on each re-entry. At the third consecutive retry the FSM enters HALT.
  - HALT holds until reset.
  - The retry counter clears on entry to FWD.
- BUMPCTRL_RETRY_EN undefined: the bumper level is not checked at TURN_x expiry, there is no retry counter, and HALT is unreachable.

## Structure
- Shared package `bumper_pkg` holds:
  - state code localparams (IDLE..HALT)
  - motor output encodings per state
  - the default cycle constants.
- Sub-module `bump_debounce` (synchronizer plus saturating counter, parameters DEBOUNCE_CYCLES and CNT_W), instantiated once per bumper.
- FSM, phase counter and output decode live in the top module.

## Test plan
Bench parameters: DEBOUNCE_CYCLES=4, BACK_CYCLES=8, TURN_CYCLES=6.

- Reset, then run=1 with no bumps → state=1 one cycle later, outputs (0,1,0,1), busy=0.
- l_bumper=0 held 10 cycles → BACK 7 cycles after the edge for exactly 8 cycles, then TURN_R for 6 cycles, then FWD.
- Both bumpers pressed in the same cycle → BACK for 8 cycles, then TURN_R for 12 cycles.
- r_bumper pulses low for 3 cycles (shorter than debounce) → no state change.
- A second bump during TURN_L is ignored.
- Reset asserted in the middle of BACK → outputs become (1,0,1,0) and state=0 with no clock edge.
- With BUMPCTRL_RETRY_EN and l_bumper held low permanently → three BACK/TURN_R cycles, then state=5 with outputs (1,0,1,0).
- Without the macro and l_bumper held low permanently → FWD after the first TURN_R, and HALT never occurs.
